// File: rtl/mem_arbiter.sv
// Fetch/data arbiter and sequencer onto the single MemControl Valid/Ready port.
// One transaction is in flight at a time; every output comes straight from a register.
module mem_arbiter #(
    parameter int DWIDTH    = 32,
    parameter int AWIDTH    = 8,
    parameter int PRIO_DATA = 1,
    parameter int TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [AWIDTH-1:0] f_addr,
    output logic              f_done,
    input  logic              d_req,
    input  logic              d_rw,
    input  logic [AWIDTH-1:0] d_addr,
    input  logic [DWIDTH-1:0] d_wdata,
    output logic              d_done,
    output logic [DWIDTH-1:0] rdata,
    output logic              err,
    output logic              timeout_seen,
    output logic [AWIDTH-1:0] mc_addr,
    output logic              mc_rw,
    output logic              mc_valid,
    output logic [DWIDTH-1:0] mc_wdata,
    input  logic [DWIDTH-1:0] mc_rdata,
    input  logic              mc_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic       OWN_F    = 1'b0;
    localparam logic       OWN_D    = 1'b1;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                f_done_q, f_done_d;
    logic                d_done_q, d_done_d;
    logic                err_q, err_d;
    logic                tseen_q, tseen_d;
    logic [AWIDTH-1:0]   mc_addr_q, mc_addr_d;
    logic                mc_rw_q, mc_rw_d;
    logic                mc_valid_q, mc_valid_d;
    logic [DWIDTH-1:0]   mc_wdata_q, mc_wdata_d;
    logic [DWIDTH-1:0]   rdata_q, rdata_d;
    logic                pick_data;

    // D wins when it is alone, when it has fixed priority, or when F was served last.
    assign pick_data = d_req && (!f_req || (PRIO_DATA != 0) || (last_grant_q == OWN_F));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        f_done_d     = 1'b0;
        d_done_d     = 1'b0;
        err_d        = 1'b0;
        tseen_d      = tseen_q;
        mc_addr_d    = mc_addr_q;
        mc_rw_d      = mc_rw_q;
        mc_valid_d   = 1'b0;
        mc_wdata_d   = mc_wdata_q;
        rdata_d      = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (f_req || d_req) begin
                    owner_d      = pick_data ? OWN_D : OWN_F;
                    last_grant_d = pick_data ? OWN_D : OWN_F;
                    mc_addr_d    = pick_data ? d_addr : f_addr;
                    mc_rw_d      = pick_data ? d_rw : 1'b1;
                    if (pick_data && !d_rw) begin
                        mc_wdata_d = d_wdata;
                    end
                    mc_valid_d   = 1'b1;
                    state_d      = S_ISSUE;
                end else begin
                    mc_rw_d = 1'b1;
                end
            end

            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // A Ready on the last permitted cycle still completes normally.
                if (mc_ready) begin
                    if (mc_rw_q) begin
                        rdata_d = mc_rdata;
                    end
                    f_done_d = (owner_q == OWN_F);
                    d_done_d = (owner_q == OWN_D);
                    state_d  = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    f_done_d = (owner_q == OWN_F);
                    d_done_d = (owner_q == OWN_D);
                    err_d    = 1'b1;
                    tseen_d  = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_DONE: begin
                mc_rw_d = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_F;
            last_grant_q <= OWN_D;
            cnt_q        <= '0;
            f_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            err_q        <= 1'b0;
            tseen_q      <= 1'b0;
            mc_addr_q    <= '0;
            mc_rw_q      <= 1'b1;
            mc_valid_q   <= 1'b0;
            mc_wdata_q   <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            f_done_q     <= f_done_d;
            d_done_q     <= d_done_d;
            err_q        <= err_d;
            tseen_q      <= tseen_d;
            mc_addr_q    <= mc_addr_d;
            mc_rw_q      <= mc_rw_d;
            mc_valid_q   <= mc_valid_d;
            mc_wdata_q   <= mc_wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    assign f_done       = f_done_q;
    assign d_done       = d_done_q;
    assign err          = err_q;
    assign timeout_seen = tseen_q;
    assign rdata        = rdata_q;
    assign mc_addr      = mc_addr_q;
    assign mc_rw        = mc_rw_q;
    assign mc_valid     = mc_valid_q;
    assign mc_wdata     = mc_wdata_q;

endmodule
